// File: rtl/heap_sort_ctrl.sv
// heap_sort_ctrl: batches an input stream into an external max-heap and drains it in sorted order.
// Build macro HEAP_SORT_ASCEND_EN inverts heap words so the drained order becomes ascending.
module heap_sort_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int SETTLE = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic                   heap_push,
  output logic                   heap_pop,
  output logic [DATA_W-1:0]      heap_data_in,
  input  logic [DATA_W-1:0]      heap_data_out,
  input  logic                   heap_empty,
  input  logic                   heap_full,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [SW-1:0] WAIT_LD = SW'(SETTLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PUSH_WAIT,
    POP,
    POP_WAIT,
    EMIT
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [SW-1:0]     settle, settle_nxt;
  logic              last_q, last_nxt;
  logic              ready_en;
  logic              ov_nxt, ol_nxt;
  logic [DATA_W-1:0] od_nxt;
  logic [DATA_W-1:0] push_word, pop_word;
  logic              accepting, xfer;

`ifdef HEAP_SORT_ASCEND_EN
  assign push_word = ~in_data;
  assign pop_word  = ~heap_data_out;
`else
  assign push_word = in_data;
  assign pop_word  = heap_data_out;
`endif

  assign accepting = (state == IDLE || state == LOAD)
                   && ready_en && (cnt < FULL) && !heap_full;
  assign in_ready  = accepting;
  assign xfer      = in_valid && accepting;

  assign heap_push    = xfer;
  assign heap_data_in = xfer ? push_word : '0;
  assign heap_pop     = (state == POP) && (cnt != '0) && !heap_empty;

  assign busy  = (state != IDLE);
  assign count = cnt;

  // Input acceptance is held off until the first edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_en <= 1'b0;
    else     ready_en <= 1'b1;
  end

  // State, occupancy, settle timer and the registered output beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      settle    <= '0;
      last_q    <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      settle    <= settle_nxt;
      last_q    <= last_nxt;
      out_valid <= ov_nxt;
      out_last  <= ol_nxt;
      out_data  <= od_nxt;
    end
  end

  // Next-state logic: fill until last/full, then pop-wait-emit per element.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    settle_nxt = settle;
    last_nxt   = last_q;
    ov_nxt     = out_valid;
    ol_nxt     = out_last;
    od_nxt     = out_data;
    unique case (state)
      IDLE, LOAD: begin
        if (xfer) begin
          cnt_nxt    = cnt + CW'(1);
          last_nxt   = in_last;
          settle_nxt = WAIT_LD;
          state_nxt  = PUSH_WAIT;
        end
      end
      PUSH_WAIT: begin
        if (settle == '0) begin
          state_nxt = (last_q || cnt == FULL) ? POP : LOAD;
        end else begin
          settle_nxt = settle - SW'(1);
        end
      end
      POP: begin
        if (cnt == '0 || heap_empty) begin
          cnt_nxt   = '0;
          last_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          settle_nxt = WAIT_LD;
          state_nxt  = POP_WAIT;
        end
      end
      POP_WAIT: begin
        if (settle == '0) begin
          od_nxt    = pop_word;
          ov_nxt    = 1'b1;
          ol_nxt    = (cnt == CW'(1));
          cnt_nxt   = cnt - CW'(1);
          state_nxt = EMIT;
        end else begin
          settle_nxt = settle - SW'(1);
        end
      end
      EMIT: begin
        if (out_ready) begin
          ov_nxt   = 1'b0;
          ol_nxt   = 1'b0;
          if (cnt != '0) begin
            state_nxt = POP;
          end else begin
            last_nxt  = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_heap_sort_ctrl.sv
// tb_heap_sort_ctrl: table vectors, directed corner sequences and random batches
// against a sort-based reference model; the external heap is modelled here too.
module tb_heap_sort_ctrl;

  localparam int DW     = 8;
  localparam int DEPTH  = 16;
  localparam int SETTLE = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_last, in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid, out_last, out_ready;
  logic [DW-1:0] out_data;
  logic          heap_push, heap_pop, heap_empty, heap_full, busy;
  logic [DW-1:0] heap_data_in, heap_data_out;
  logic [$clog2(DEPTH):0] count;

  heap_sort_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .heap_push(heap_push), .heap_pop(heap_pop), .heap_data_in(heap_data_in),
    .heap_data_out(heap_data_out), .heap_empty(heap_empty), .heap_full(heap_full),
    .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  // external max-heap: a pop returns the largest stored word on heap_data_out
  logic [DW-1:0] hmem [DEPTH];
  int            hsize;
  logic [DW-1:0] hout;
  assign heap_data_out = hout;
  assign heap_empty    = (hsize == 0);
  assign heap_full     = (hsize >= DEPTH);

  always @(posedge clk or posedge rst) begin : heap_model
    int mi;
    if (rst) begin
      hsize <= 0;
      hout  <= '0;
    end else if (heap_push && hsize < DEPTH) begin
      hmem[hsize] <= heap_data_in;
      hsize       <= hsize + 1;
    end else if (heap_pop && hsize > 0) begin
      mi = 0;
      for (int i = 1; i < hsize; i++)
        if (hmem[i] > hmem[mi]) mi = i;
      hout     <= hmem[mi];
      hmem[mi] <= hmem[hsize-1];
      hsize    <= hsize - 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] cur[$];
  logic [DW-1:0] got_q[$];
  int            cyc = 0;
  int            pop_cnt = 0;
  int            pop_cyc = -1;
  logic          prev_hold = 1'b0;
  logic          prev_valid = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  // batch closes on in_last or when DEPTH beats are held
  task automatic flush_batch();
`ifdef HEAP_SORT_ASCEND_EN
    cur.sort();
`else
    cur.rsort();
`endif
    for (int i = 0; i < cur.size(); i++) begin
      beat_t b;
      b.d = cur[i];
      b.l = (i == cur.size() - 1);
      exp_q.push_back(b);
    end
    cur.delete();
  endtask

  // sampled on the falling edge, mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      cur.delete();
      pop_cyc    = -1;
      prev_hold  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (heap_push || heap_pop)
        check("push_pop_excl", 32'(heap_push & heap_pop), 0);
      if (heap_pop) begin
        pop_cnt++;
        pop_cyc = cyc;
      end
      if (out_valid && !prev_valid && pop_cyc >= 0)
        check("pop_latency", cyc - pop_cyc, SETTLE + 1);
      if (prev_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_last", out_last, prev_last);
      end
      prev_hold  = out_valid && !out_ready;
      prev_valid = out_valid;
      prev_data  = out_data;
      prev_last  = out_last;
      if (in_valid && in_ready) begin
        cur.push_back(in_data);
        if (in_last || cur.size() == DEPTH) flush_batch();
      end
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        check("out_beat_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          beat_t e;
          e = exp_q.pop_front();
          check("out_data", out_data, e.d);
          check("out_last", out_last, e.l);
        end
      end
    end
  end

  // out_ready mode: 0 always ready, 1 random, 2 stalled
  int rmode = 0;
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  logic acc_busy;

  task automatic send_beat(input logic [DW-1:0] d, input logic l, input int gap);
    int k;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    check("accept_timeout", 32'(k >= 3000), 0);
    acc_busy = busy;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
    end
    check("idle_timeout", 32'(k >= 5000), 0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int            n;
    logic [DW-1:0] din [4];
    logic [DW-1:0] dexp[4];
  } vec_t;

  vec_t tv[4];

  initial begin
    int k;
    logic [DW-1:0] first_exp;

    tv[0].n = 4; tv[0].din = '{5, 3, 9, 1};
    tv[1].n = 3; tv[1].din = '{7, 7, 2, 0};
    tv[2].n = 1; tv[2].din = '{42, 0, 0, 0};
    tv[3].n = 3; tv[3].din = '{200, 10, 50, 0};
`ifdef HEAP_SORT_ASCEND_EN
    tv[0].dexp = '{1, 3, 5, 9};
    tv[1].dexp = '{2, 7, 7, 0};
    tv[2].dexp = '{42, 0, 0, 0};
    tv[3].dexp = '{10, 50, 200, 0};
    first_exp  = 8'd2;
`else
    tv[0].dexp = '{9, 5, 3, 1};
    tv[1].dexp = '{7, 7, 2, 0};
    tv[2].dexp = '{42, 0, 0, 0};
    tv[3].dexp = '{200, 50, 10, 0};
    first_exp  = 8'd7;
`endif

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    rmode    = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_heap_push", heap_push, 0);
    check("rst_heap_pop", heap_pop, 0);
    check("rst_heap_data_in", heap_data_in, 0);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_before_edge", in_ready, 0);
    @(negedge clk);
    check("in_ready_after_edge", in_ready, 1);
    @(posedge clk);
    #1;

    // table vectors
    for (int v = 0; v < 4; v++) begin
      got_q.delete();
      pop_cnt = 0;
      for (int i = 0; i < tv[v].n; i++)
        send_beat(tv[v].din[i], i == tv[v].n - 1, 0);
      wait_idle();
      check("tv_len", got_q.size(), tv[v].n);
      for (int i = 0; i < tv[v].n && i < got_q.size(); i++)
        check("tv_data", got_q[i], tv[v].dexp[i]);
      check("tv_pops", pop_cnt, tv[v].n);
      check("tv_count_end", count, 0);
      check("tv_busy_end", busy, 0);
    end

    // output stall holds the first beat stable
    rmode = 2;
    send_beat(7, 0, 0);
    send_beat(7, 0, 0);
    send_beat(2, 1, 0);
    for (k = 0; k < 500; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("stall_valid_timeout", 32'(k >= 500), 0);
    repeat (10) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, first_exp);
    end
    rmode = 0;
    wait_idle();

    // full heap without in_last truncates the batch
    got_q.delete();
    for (int i = 0; i < 16; i++) send_beat(8'(i), 0, 0);
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("full_count", count, 16);
    @(posedge clk);
    #1;
    send_beat(100, 1, 0);
    check("beat17_after_idle", acc_busy, 0);
    wait_idle();
    check("full_len", got_q.size(), 17);
    for (int i = 0; i < 16 && i < got_q.size(); i++)
`ifdef HEAP_SORT_ASCEND_EN
      check("full_data", got_q[i], i);
`else
      check("full_data", got_q[i], 15 - i);
`endif
    if (got_q.size() == 17) check("beat17_data", got_q[16], 100);

    // reset during POP_WAIT
    send_beat(11, 0, 0);
    send_beat(22, 0, 0);
    send_beat(33, 0, 0);
    send_beat(44, 1, 0);
    for (k = 0; k < 500; k++) begin
      @(negedge clk);
      if (heap_pop) break;
    end
    check("pop_wait_timeout", 32'(k >= 500), 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_count", count, 0);
    check("midrst_heap_pop", heap_pop, 0);
    check("midrst_out_data", out_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    got_q.delete();
    send_beat(8, 1, 0);
    wait_idle();
    check("postrst_len", got_q.size(), 1);
    if (got_q.size() == 1) check("postrst_data", got_q[0], 8);

    // random batches with random gaps and backpressure
    rmode = 1;
    for (int b = 0; b < 40; b++) begin
      int len;
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++)
        send_beat(8'($urandom_range(0, 255)), i == len - 1, $urandom_range(0, 2));
      wait_idle();
    end
    rmode = 0;
    check("final_exp_empty", exp_q.size(), 0);
    check("final_count", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
